// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage -- execute stage of a 5-stage MIPS-style pipeline.
//
// Purpose:
//   Resolves operand forwarding, runs the single-cycle ALU and hosts a shared
//   iterative unsigned multiply/divide unit with its HI/LO registers. Results
//   and pass-through controls are registered into the EX/MEM boundary.
//
// Ports:
//   clk_i                 clock
//   start_i               asynchronous active-low reset
//   RDData0_i/RDData1_i   register-file values for RS/RT
//   SignExtended_i        immediate; bits [5:0] carry funct for R-type
//   RSaddr_i/RTaddr_i     source register numbers (forwarding compare)
//   RegDst_i              destination register number
//   ALUOp_i               00 add, 01 sub, 10 R-type by funct, 11 add
//   ALUSrc_i              1 selects the immediate as operand B
//   RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i   pass-through controls
//   WB_RegWrite_i/WB_RegDst_i/WB_Data_i             MEM/WB forwarding source
//   ALUResult_o, WriteData_o, RegDst_o, RegWrite_o, MemToReg_o, MemRead_o,
//   MemWrite_o            registered EX/MEM outputs
//   stall_o               hold IF/ID and ID/EX this cycle
//   busy_o                multiply/divide unit active (also the FSM state)
//
// Stall handshake: stall_o is combinational from the instruction presented
// this cycle. When it is 1 the instruction is NOT consumed: EX/MEM loads a
// bubble at the next edge and upstream must present the same instruction
// again. When it is 0 the presented instruction is consumed at that edge.
// ----------------------------------------------------------------------------
module ex_stage (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [31:0] RDData0_i,
    input  logic [31:0] RDData1_i,
    input  logic [31:0] SignExtended_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  RegDst_i,
    input  logic [1:0]  ALUOp_i,
    input  logic        ALUSrc_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        WB_RegWrite_i,
    input  logic [4:0]  WB_RegDst_i,
    input  logic [31:0] WB_Data_i,
    output logic [31:0] ALUResult_o,
    output logic [31:0] WriteData_o,
    output logic [4:0]  RegDst_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        stall_o,
    output logic        busy_o
);

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    md_state_t md_state_q, md_state_d;

    // ------------------------------------------------------------------
    // Instruction decode for the hazard logic
    // ------------------------------------------------------------------
    logic [5:0] funct;
    logic       is_rtype;
    logic       is_md;
    logic       uses_hilo;
    logic       stall;
    logic       issue;

    assign funct     = SignExtended_i[5:0];
    assign is_rtype  = (ALUOp_i == 2'b10);
    assign is_md     = is_rtype && ((funct == FN_MULTU) || (funct == FN_DIVU));
    assign uses_hilo = is_md || (is_rtype && ((funct == FN_MFHI) || (funct == FN_MFLO)));

    assign busy_o  = (md_state_q != MD_IDLE);
    // busy_o is forced low by reset, so stall is also low during reset.
    assign stall   = busy_o && uses_hilo;
    assign stall_o = stall;
    assign issue   = is_md && !busy_o;

    // ------------------------------------------------------------------
    // Forwarding: the instruction now in EX/MEM is younger than the one in
    // MEM/WB, so it wins. Register 0 is never forwarded.
    // ------------------------------------------------------------------
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;

    always_comb begin
        fwd_a = RDData0_i;
        if (RegWrite_o && (RegDst_o != 5'd0) && (RegDst_o == RSaddr_i)) begin
            fwd_a = ALUResult_o;
        end else if (WB_RegWrite_i && (WB_RegDst_i != 5'd0) && (WB_RegDst_i == RSaddr_i)) begin
            fwd_a = WB_Data_i;
        end

        fwd_b = RDData1_i;
        if (RegWrite_o && (RegDst_o != 5'd0) && (RegDst_o == RTaddr_i)) begin
            fwd_b = ALUResult_o;
        end else if (WB_RegWrite_i && (WB_RegDst_i != 5'd0) && (WB_RegDst_i == RTaddr_i)) begin
            fwd_b = WB_Data_i;
        end
    end

    assign op_b = ALUSrc_i ? SignExtended_i : fwd_b;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [31:0] hi_q, lo_q;
    logic [31:0] alu_res;

    always_comb begin
        alu_res = 32'd0;
        case (ALUOp_i)
            2'b01: alu_res = fwd_a - op_b;
            2'b10: begin
                case (funct)
                    FN_ADD:  alu_res = fwd_a + op_b;
                    FN_SUB:  alu_res = fwd_a - op_b;
                    FN_AND:  alu_res = fwd_a & op_b;
                    FN_OR:   alu_res = fwd_a | op_b;
                    FN_SLT:  alu_res = ($signed(fwd_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    FN_MFHI: alu_res = hi_q;
                    FN_MFLO: alu_res = lo_q;
                    default: alu_res = 32'd0;
                endcase
            end
            default: alu_res = fwd_a + op_b;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply/divide control FSM
    // ------------------------------------------------------------------
    logic [5:0] cnt_q;
    logic       last_iter;

    assign last_iter = (cnt_q == 6'd31);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            md_state_q <= MD_IDLE;
        end else begin
            md_state_q <= md_state_d;
        end
    end

    always_comb begin
        md_state_d = md_state_q;
        case (md_state_q)
            MD_IDLE: begin
                if (issue) begin
                    md_state_d = (funct == FN_DIVU) ? MD_DIV : MD_MUL;
                end
            end
            MD_MUL, MD_DIV: begin
                if (last_iter) begin
                    md_state_d = MD_IDLE;
                end
            end
            default: md_state_d = MD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of the shared datapath.
    // multu: {work_hi, work_lo} is the product register; work_lo starts as
    //        the multiplier and is shifted out LSB first while the partial
    //        sum (33 bits, carry kept) shifts in from the top.
    // divu:  work_hi is the partial remainder, work_lo starts as the
    //        dividend and collects quotient bits. A zero divisor always
    //        "fits", which naturally yields LO=all ones and HI=dividend.
    // ------------------------------------------------------------------
    logic [31:0] a_q, b_q;
    logic [31:0] work_hi_q, work_lo_q;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [31:0] iter_hi, iter_lo;

    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : 33'd0);
        div_shift = {work_hi_q, work_lo_q[31]};
        div_ge    = (div_shift >= {1'b0, b_q});
        // Remainder stays below the divisor, so the difference fits 32 bits.
        div_diff  = div_shift[31:0] - b_q;
        iter_hi   = work_hi_q;
        iter_lo   = work_lo_q;
        if (md_state_q == MD_MUL) begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], work_lo_q[31:1]};
        end else if (md_state_q == MD_DIV) begin
            iter_hi = div_ge ? div_diff : div_shift[31:0];
            iter_lo = {work_lo_q[30:0], div_ge};
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            cnt_q     <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            work_hi_q <= 32'd0;
            work_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else if (issue) begin
            cnt_q     <= 6'd0;
            a_q       <= fwd_a;
            b_q       <= op_b;
            work_hi_q <= 32'd0;
            work_lo_q <= (funct == FN_DIVU) ? fwd_a : op_b;
        end else if (busy_o) begin
            cnt_q     <= cnt_q + 6'd1;
            work_hi_q <= iter_hi;
            work_lo_q <= iter_lo;
            // HI/LO become visible only when the final iteration completes.
            if (last_iter) begin
                hi_q <= iter_hi;
                lo_q <= iter_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register. A stalled instruction or a mult/div issue leaves a
    // bubble: mult/div never writes a GPR from this path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            ALUResult_o <= 32'd0;
            WriteData_o <= 32'd0;
            RegDst_o    <= 5'd0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            MemRead_o   <= 1'b0;
            MemWrite_o  <= 1'b0;
        end else if (stall || issue) begin
            ALUResult_o <= 32'd0;
            WriteData_o <= 32'd0;
            RegDst_o    <= 5'd0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            MemRead_o   <= 1'b0;
            MemWrite_o  <= 1'b0;
        end else begin
            ALUResult_o <= alu_res;
            WriteData_o <= fwd_b;
            RegDst_o    <= RegDst_i;
            RegWrite_o  <= RegWrite_i;
            MemToReg_o  <= MemToReg_i;
            MemRead_o   <= MemRead_i;
            MemWrite_o  <= MemWrite_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
// A behavioural model predicts every EX/MEM output, busy_o and stall_o using
// plain arithmetic (64-bit product, / and %) and a remaining-cycles counter
// for the multiply/divide latency. Directed steps first, then random traffic.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic start_i;
    always #5 clk_i = ~clk_i;

    logic [31:0] RDData0_i, RDData1_i, SignExtended_i, WB_Data_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RegDst_i, WB_RegDst_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, WB_RegWrite_i;
    logic [31:0] ALUResult_o, WriteData_o;
    logic [4:0]  RegDst_o;
    logic        RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, stall_o, busy_o;

    ex_stage dut (
        .clk_i(clk_i), .start_i(start_i),
        .RDData0_i(RDData0_i), .RDData1_i(RDData1_i), .SignExtended_i(SignExtended_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RegDst_i(RegDst_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
        .MemToReg_i(MemToReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .WB_RegWrite_i(WB_RegWrite_i), .WB_RegDst_i(WB_RegDst_i), .WB_Data_i(WB_Data_i),
        .ALUResult_o(ALUResult_o), .WriteData_o(WriteData_o), .RegDst_o(RegDst_o),
        .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .stall_o(stall_o), .busy_o(busy_o)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];   // pending {HI, LO} result of the in-flight mult/div

    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_rd;
    logic        e_rw, e_mtr, e_mr, e_mw;
    logic        e_stall;
    logic        last_stall;
    int          m_left;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_alu = '0; e_wd = '0; e_rd = '0;
        e_rw = 1'b0; e_mtr = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
        m_left = 0; m_hi = '0; m_lo = '0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf);
        if (e_rw && e_rd != 5'd0 && e_rd == addr) return e_alu;
        if (WB_RegWrite_i && WB_RegDst_i != 5'd0 && WB_RegDst_i == addr) return WB_Data_i;
        return rf;
    endfunction

    function automatic logic is_md_op();
        return ALUOp_i == 2'b10 && (SignExtended_i[5:0] == FN_MULTU || SignExtended_i[5:0] == FN_DIVU);
    endfunction

    function automatic logic model_stall();
        logic [5:0] f;
        f = SignExtended_i[5:0];
        return (m_left > 0) && ALUOp_i == 2'b10 &&
               (f == FN_MULTU || f == FN_DIVU || f == FN_MFHI || f == FN_MFLO);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
        case (ALUOp_i)
            2'b01: return a - b;
            2'b10: begin
                case (SignExtended_i[5:0])
                    FN_ADD:  return a + b;
                    FN_SUB:  return a - b;
                    FN_AND:  return a & b;
                    FN_OR:   return a | b;
                    FN_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    FN_MFHI: return m_hi;
                    FN_MFLO: return m_lo;
                    default: return 32'd0;
                endcase
            end
            default: return a + b;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] a, b, bb;
        logic [63:0] prod;
        logic        stl, iss;
        a   = fwd(RSaddr_i, RDData0_i);
        b   = fwd(RTaddr_i, RDData1_i);
        bb  = ALUSrc_i ? SignExtended_i : b;
        stl = model_stall();
        iss = is_md_op() && (m_left == 0);
        if (stl || iss) begin
            e_alu = '0; e_wd = '0; e_rd = '0;
            e_rw = 1'b0; e_mtr = 1'b0; e_mr = 1'b0; e_mw = 1'b0;
        end else begin
            e_alu = ref_alu(a, bb); e_wd = b; e_rd = RegDst_i;
            e_rw = RegWrite_i; e_mtr = MemToReg_i; e_mr = MemRead_i; e_mw = MemWrite_i;
        end
        if (iss) begin
            m_left = 32;
            exp_q.delete();
            if (SignExtended_i[5:0] == FN_MULTU) begin
                prod = {32'd0, a} * {32'd0, bb};
                exp_q.push_back(prod[63:32]);
                exp_q.push_back(prod[31:0]);
            end else if (bb == 32'd0) begin
                exp_q.push_back(a);
                exp_q.push_back(32'hFFFF_FFFF);
            end else begin
                exp_q.push_back(a % bb);
                exp_q.push_back(a / bb);
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = exp_q.pop_front();
                m_lo = exp_q.pop_front();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/alu"},   ALUResult_o, e_alu);
        chk({tag, "/wdata"}, WriteData_o, e_wd);
        chk({tag, "/rd"},    {27'd0, RegDst_o}, {27'd0, e_rd});
        chk({tag, "/ctl"},   {28'd0, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o},
                             {28'd0, e_rw, e_mtr, e_mr, e_mw});
        chk({tag, "/busy"},  {31'd0, busy_o}, {31'd0, m_left > 0});
    endtask

    // One clock: check combinational stall, take the edge, check registers.
    task automatic cycle(input string tag);
        #1;
        e_stall    = model_stall();
        last_stall = stall_o;
        chk({tag, "/stall"}, {31'd0, stall_o}, {31'd0, e_stall});
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_nop();
        RDData0_i = '0; RDData1_i = '0; SignExtended_i = '0;
        RSaddr_i = '0; RTaddr_i = '0; RegDst_i = '0; ALUOp_i = 2'b00;
        ALUSrc_i = 1'b0; RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        WB_RegWrite_i = 1'b0; WB_RegDst_i = '0; WB_Data_i = '0;
    endtask

    task automatic set_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rw);
        set_nop();
        ALUOp_i = 2'b10; SignExtended_i = {26'd0, f};
        RSaddr_i = rs; RTaddr_i = rt; RegDst_i = rd;
        RDData0_i = d0; RDData1_i = d1; RegWrite_i = rw;
    endtask

    // Hold the current instruction until the model says it has been consumed.
    task automatic wait_through(input string tag, output int stalls);
        int n;
        stalls = 0;
        n = 0;
        do begin
            cycle(tag);
            if (last_stall === 1'b1) stalls++;
            n++;
        end while (e_stall && n < 40);
    endtask

    int stalls;
    logic [5:0] rand_fn[10] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT,
                                FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO, 6'h3F};

    initial begin
        start_i = 1'b0;
        set_nop();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("reset");
        chk("reset/stall", {31'd0, stall_o}, 32'd0);
        #3 start_i = 1'b1;

        // Forward priority: EX/MEM beats MEM/WB.
        set_r(FN_ADD, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 1'b1);
        cycle("fwd_setup");
        set_r(FN_ADD, 5'd5, 5'd0, 5'd9, 32'h55, 32'd0, 1'b1);
        WB_RegWrite_i = 1'b1; WB_RegDst_i = 5'd5; WB_Data_i = 32'd9;
        cycle("fwd_prio");
        chk("fwd_prio_val", ALUResult_o, 32'd7);

        // R0 is never forwarded.
        set_r(FN_ADD, 5'd1, 5'd2, 5'd0, 32'hFF, 32'd0, 1'b1);
        cycle("r0_setup");
        set_r(FN_ADD, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 1'b1);
        cycle("r0_guard");
        chk("r0_guard_val", ALUResult_o, 32'd0);

        // Immediate path, sub and slt.
        set_nop(); ALUOp_i = 2'b01; ALUSrc_i = 1'b1; SignExtended_i = 32'd10;
        RDData0_i = 32'd4; RegDst_i = 5'd7; RegWrite_i = 1'b1; MemRead_i = 1'b1;
        cycle("sub_imm");
        chk("sub_imm_val", ALUResult_o, 32'hFFFF_FFFA);
        set_r(FN_SLT, 5'd1, 5'd2, 5'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        cycle("slt");
        chk("slt_val", ALUResult_o, 32'd1);

        // multu max x max, mflo presented 5 cycles after issue.
        set_r(FN_MULTU, 5'd1, 5'd2, 5'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        cycle("multu_issue");
        chk("multu_rw", {31'd0, RegWrite_o}, 32'd0);
        set_nop();
        repeat (4) cycle("mul_nop");
        set_r(FN_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        wait_through("mflo_wait", stalls);
        chk("mflo_stall_cycles", stalls, 28);
        chk("mflo_val", ALUResult_o, 32'd1);
        chk("mflo_rw", {31'd0, RegWrite_o}, 32'd1);
        set_r(FN_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        cycle("mfhi");
        chk("mfhi_val", ALUResult_o, 32'hFFFF_FFFE);

        // divu 100/7 and 5/0.
        set_r(FN_DIVU, 5'd1, 5'd2, 5'd0, 32'd100, 32'd7, 1'b0);
        cycle("divu_issue");
        set_r(FN_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        wait_through("div_wait", stalls);
        chk("div_stall_cycles", stalls, 32);
        chk("div_lo", ALUResult_o, 32'd14);
        set_r(FN_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        cycle("div_mfhi");
        chk("div_hi", ALUResult_o, 32'd2);
        set_r(FN_DIVU, 5'd1, 5'd2, 5'd0, 32'd5, 32'd0, 1'b0);
        cycle("div0_issue");
        set_r(FN_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        wait_through("div0_wait", stalls);
        chk("div0_lo", ALUResult_o, 32'hFFFF_FFFF);
        set_r(FN_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        cycle("div0_mfhi");
        chk("div0_hi", ALUResult_o, 32'd5);

        // Independent add proceeds while busy.
        set_r(FN_MULTU, 5'd1, 5'd2, 5'd0, 32'd3, 32'd5, 1'b0);
        cycle("mul2_issue");
        set_r(FN_ADD, 5'd1, 5'd2, 5'd9, 32'd3, 32'd4, 1'b1);
        cycle("add_busy");
        chk("add_busy_nostall", {31'd0, last_stall}, 32'd0);
        chk("add_busy_val", ALUResult_o, 32'd7);
        set_r(FN_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        wait_through("mul2_wait", stalls);
        chk("mul2_lo", ALUResult_o, 32'd15);

        // Reset at iteration 10 of a multiply.
        set_r(FN_MULTU, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cycle("mul3_issue");
        set_nop();
        repeat (10) cycle("mul3_nop");
        set_r(FN_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        #2 start_i = 1'b0;
        model_reset();
        #1;
        check_outputs("abort");
        chk("abort/stall", {31'd0, stall_o}, 32'd0);
        #1 start_i = 1'b1;
        cycle("post_rst_mflo");
        chk("post_rst_lo", ALUResult_o, 32'd0);
        set_r(FN_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 1'b1);
        cycle("post_rst_mfhi");
        chk("post_rst_hi", ALUResult_o, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_nop();
            ALUOp_i        = 2'($urandom_range(0, 3));
            SignExtended_i = {$urandom_range(0, 3) == 0 ? 26'($urandom) : 26'd0,
                              rand_fn[$urandom_range(0, 9)]};
            ALUSrc_i       = ($urandom_range(0, 3) == 0);
            RSaddr_i       = 5'($urandom_range(0, 3));
            RTaddr_i       = 5'($urandom_range(0, 3));
            RegDst_i       = 5'($urandom_range(0, 3));
            RDData0_i      = $urandom;
            RDData1_i      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            RegWrite_i     = 1'($urandom_range(0, 1));
            MemToReg_i     = 1'($urandom_range(0, 1));
            MemRead_i      = 1'($urandom_range(0, 1));
            MemWrite_i     = 1'($urandom_range(0, 1));
            WB_RegWrite_i  = 1'($urandom_range(0, 1));
            WB_RegDst_i    = 5'($urandom_range(0, 3));
            WB_Data_i      = $urandom;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
